xfire_serial_tx: RTL
====================

// Module: xfire_serial_tx
// PURPOSE
//  Serializer for the xfire digital top: sends parallel config/readback words off-chip
//  over a 3-wire serial link (cs_n, sclk, sdo), mode-0 timing (sdo driven on sclk low,
//  sampled by the far end on the sclk rising edge). Transmit counterpart to the top-level
//  serial receive path; words are accepted through a valid/ready handshake.
// PARAMETERS
//  DATA_WIDTH   16  bits per frame (>=2)
//  CLK_DIV      4   clk cycles per sclk half-period (>=1)
//  MSB_FIRST    1   1: bit DATA_WIDTH-1 sent first; 0: bit 0 sent first
//  IDLE_CYCLES  2   clk cycles cs_n held high after a frame before next accept (>=1)
// PORTS
//  clk         in   1   posedge clock
//  arst        in   1   asynchronous reset, active-high
//  srst        in   1   synchronous reset, active-high
//  enable      in   1   synchronous clock enable; low freezes all state and outputs
//  tx_data     in   DW  word to transmit, sampled on handshake
//  tx_valid    in   1   tx_data valid
//  tx_ready    out  1   block can accept a word this cycle
//  cs_n        out  1   frame select, active-low (registered)
//  sclk        out  1   serial clock, idle low (registered)
//  sdo         out  1   serial data (registered)
//  busy        out  1   frame or inter-frame gap in progress
//  frame_done  out  1   one-cycle pulse on completion of a full frame
// BEHAVIOUR
//  Priority: arst > srst > enable. srst has exactly the effect of arst, taken synchronously.
//  Reset values: cs_n=1, sclk=0, sdo=0, busy=0, frame_done=0; state IDLE, all counters 0.
//  tx_ready = (state==IDLE) & enable & ~srst (combinational); handshake = tx_valid & tx_ready.
//  FSM: IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
//   IDLE : cs_n=1, sclk=0, sdo=0. On handshake at cycle T0: load shift reg, go SHIFT.
//   SHIFT: from T0+1: cs_n=0, sdo=first bit, sclk=0. Each bit occupies 2*CLK_DIV cycles:
//          CLK_DIV cycles with sclk=0, then CLK_DIV cycles with sclk=1. sdo changes only
//          when sclk goes 1->0 (and at frame start). Bit counter counts DATA_WIDTH bits.
//   HOLD : after the last high phase, sclk=0 and cs_n=0 for CLK_DIV cycles; sdo holds last bit.
//   GAP  : cs_n=1, sdo=0, frame_done=1 on the first GAP cycle only; lasts IDLE_CYCLES.
//  Timing: cs_n low T0+1 .. T0+(2*DW+1)*CLK_DIV; cs_n rises at T0+1+(2*DW+1)*CLK_DIV;
//   tx_ready high again IDLE_CYCLES cycles later. Defaults: cs_n rises T0+133, ready T0+135.
//  busy = (state != IDLE). tx_data/tx_valid ignored while busy; no queuing.
//  enable=0 mid-frame: counters, shift reg and outputs hold; the frame resumes unchanged
//   (stretched sclk phase); tx_ready=0 while enable=0.
//  arst/srst mid-frame: frame aborted, cs_n=1 and sclk=0 immediately (arst) or next edge
//   (srst); no frame_done; next frame starts from the first bit of a new word.
//  Widths: div counter $clog2(CLK_DIV) (min 1 bit), wraps at CLK_DIV-1; bit counter
//   $clog2(DATA_WIDTH+1). No arithmetic overflow reachable for legal parameters.
// STRUCTURE
//  xfire_defs.vh: FSM state encoding localparams, serial-mode constants shared with the
//   receive path. One sub-module: xfire_tick_gen (CLK_DIV half-period tick counter with
//   enable/srst/clear); shift register and FSM live in this module.
//  RTL_DEBUG assertions: cs_n never low in IDLE/GAP; sdo stable while sclk=1;
//   frame_done one cycle wide; exactly DATA_WIDTH sclk rising edges per completed frame.
// TESTING
//  1 Defaults, MSB_FIRST=1, send 16'hA5C3 -> 16 sclk rises, receiver model samples A5C3,
//    cs_n low cycles 1..132, frame_done at 133, tx_ready at 135.
//  2 MSB_FIRST=0, CLK_DIV=1, send 16'h0001 -> first bit 1, then 15 zeros; sclk period 2 clk.
//  3 Back-to-back: tx_valid held with 16'h1234 then 16'hFEDC -> second accept exactly
//    IDLE_CYCLES after cs_n rise; both words received in order; tx_data changes mid-frame ignored.
//  4 enable low 10 cycles during bit 5 high phase -> all outputs frozen, word still correct,
//    frame_done delayed by 10 cycles.
//  5 arst pulse during bit 8 -> cs_n=1, sclk=0 in same cycle, no frame_done; next word 16'h00FF
//    transmitted intact. Repeat with srst -> same result one edge later.
//  6 tx_valid=1 during srst or enable=0 -> no accept, tx_ready=0, cs_n stays high.

Source files
------------

// File: rtl/xfire_serial_tx_pkg.sv
// ---------------------------------------------------------------------------
// xfire_serial_tx_pkg
//   Shared definitions for the xfire serial transmit path: FSM state encoding,
//   idle levels of the 3-wire link (also used by the receive side) and a
//   counter-width helper.
// ---------------------------------------------------------------------------
package xfire_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Idle levels of the mode-0 link.
    localparam logic CS_N_IDLE = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic SDO_IDLE  = 1'b0;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xfire_serial_tx_if.sv
// ---------------------------------------------------------------------------
// xfire_serial_tx_if
//   Valid/ready word handshake into the serializer.
//   tx_data  : word to transmit, sampled when tx_valid & tx_ready
//   tx_valid : tx_data is valid
//   tx_ready : serializer can accept a word this cycle
// ---------------------------------------------------------------------------
interface xfire_serial_tx_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/xfire_tick_gen.sv
// ---------------------------------------------------------------------------
// xfire_tick_gen
//   Half-period tick counter for the serial clock. Counts 0..CLK_DIV-1 while
//   enabled and pulses tick on the last count of each half period.
//   clk    : posedge clock
//   arst   : asynchronous reset, active-high
//   srst   : synchronous reset, active-high
//   enable : clock enable; low holds the count and suppresses tick
//   clear  : hold the count at zero (idle / inter-frame gap)
//   tick   : last cycle of the current half period
// ---------------------------------------------------------------------------
module xfire_tick_gen
    import xfire_serial_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic arst,
    input  logic srst,
    input  logic enable,
    input  logic clear,
    output logic tick
);
    localparam int                DIV_W    = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick = enable & ~clear & (div_cnt == DIV_LAST);

    // NOTE: sequential state is written only with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            div_cnt <= '0;
        end else if (srst) begin
            div_cnt <= '0;
        end else if (enable) begin
            if (clear || div_cnt == DIV_LAST) div_cnt <= '0;
            else                              div_cnt <= div_cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/xfire_serial_tx.sv
// ---------------------------------------------------------------------------
// xfire_serial_tx
//   Mode-0 serializer for the xfire digital top. Accepts a word over a
//   valid/ready handshake and shifts it out on cs_n/sclk/sdo, sdo changing
//   while sclk is low and sampled by the far end on sclk rising edges.
//   Frame: SHIFT (DATA_WIDTH bits, 2*CLK_DIV clk each), HOLD (CLK_DIV clk,
//   cs_n still low), GAP (IDLE_CYCLES clk, cs_n high) then back to IDLE.
//   clk        : posedge clock
//   arst       : asynchronous reset, active-high
//   srst       : synchronous reset, active-high (same effect as arst)
//   enable     : clock enable; low freezes all state and outputs
//   tx         : word handshake (slave side)
//   cs_n       : frame select, active-low, registered
//   sclk       : serial clock, idle low, registered
//   sdo        : serial data, registered
//   busy       : frame or inter-frame gap in progress
//   frame_done : one-cycle pulse on the first gap cycle of a completed frame
// ---------------------------------------------------------------------------
module xfire_serial_tx
    import xfire_serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CLK_DIV     = 4,
    parameter int MSB_FIRST   = 1,
    parameter int IDLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               srst,
    input  logic               enable,
    xfire_serial_tx_if.slave   tx,
    output logic               cs_n,
    output logic               sclk,
    output logic               sdo,
    output logic               busy,
    output logic               frame_done
);
    localparam int               BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam int               GAP_W    = cnt_width(IDLE_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_CYCLES - 1);

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] sreg, sreg_n;
    logic [BIT_W-1:0]      bit_cnt, bit_cnt_n;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_n;
    logic                  cs_n_n, sclk_n, sdo_n, frame_done_n;
    logic                  tick, handshake;

    // Bit that goes on the wire next, and the word with that bit consumed.
    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] drop_bit(input logic [DATA_WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    assign tx.tx_ready = (state == ST_IDLE) & enable & ~srst;
    assign handshake   = tx.tx_valid & tx.tx_ready;
    assign busy        = (state != ST_IDLE);

    // The half-period counter only runs while a frame is on the wire, so
    // every frame starts at the beginning of a low phase.
    xfire_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk    (clk),
        .arst   (arst),
        .srst   (srst),
        .enable (enable),
        .clear  (state == ST_IDLE || state == ST_GAP),
        .tick   (tick)
    );

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n      = state;
        sreg_n       = sreg;
        bit_cnt_n    = bit_cnt;
        gap_cnt_n    = gap_cnt;
        cs_n_n       = cs_n;
        sclk_n       = sclk;
        sdo_n        = sdo;
        frame_done_n = 1'b0;

        unique case (state)
            ST_IDLE: begin
                cs_n_n = CS_N_IDLE;
                sclk_n = SCLK_IDLE;
                sdo_n  = SDO_IDLE;
                if (handshake) begin
                    state_n   = ST_SHIFT;
                    cs_n_n    = 1'b0;
                    sdo_n     = first_bit(tx.tx_data);
                    sreg_n    = drop_bit(tx.tx_data);
                    bit_cnt_n = '0;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        // Falling edge: advance to the next bit, or finish.
                        sclk_n = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = ST_HOLD;
                        end else begin
                            bit_cnt_n = bit_cnt + BIT_W'(1);
                            sdo_n     = first_bit(sreg);
                            sreg_n    = drop_bit(sreg);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (tick) begin
                    state_n      = ST_GAP;
                    cs_n_n       = CS_N_IDLE;
                    sdo_n        = SDO_IDLE;
                    frame_done_n = 1'b1;
                    bit_cnt_n    = '0;
                    gap_cnt_n    = '0;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) state_n   = ST_IDLE;
                else                     gap_cnt_n = gap_cnt + GAP_W'(1);
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // NOTE: the shift register is reset along with the control state; it is
    // a single word, and a defined value keeps aborted frames reproducible.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            cs_n       <= CS_N_IDLE;
            sclk       <= SCLK_IDLE;
            sdo        <= SDO_IDLE;
            frame_done <= 1'b0;
        end else if (srst) begin
            state      <= ST_IDLE;
            sreg       <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            cs_n       <= CS_N_IDLE;
            sclk       <= SCLK_IDLE;
            sdo        <= SDO_IDLE;
            frame_done <= 1'b0;
        end else if (enable) begin
            state      <= state_n;
            sreg       <= sreg_n;
            bit_cnt    <= bit_cnt_n;
            gap_cnt    <= gap_cnt_n;
            cs_n       <= cs_n_n;
            sclk       <= sclk_n;
            sdo        <= sdo_n;
            frame_done <= frame_done_n;
        end
    end

`ifdef RTL_DEBUG
    logic [BIT_W:0] dbg_rises;

    always_ff @(posedge clk or posedge arst) begin
        if (arst)                             dbg_rises <= '0;
        else if (srst || (enable && handshake)) dbg_rises <= '0;
        else if (enable && sclk_n && !sclk)   dbg_rises <= dbg_rises + (BIT_W+1)'(1);
    end

    a_cs_n_idle: assert property (@(posedge clk) disable iff (arst)
        (state == ST_IDLE || state == ST_GAP) |-> cs_n);
    a_sdo_stable: assert property (@(posedge clk) disable iff (arst || srst)
        (sclk && $past(sclk)) |-> $stable(sdo));
    a_done_pulse: assert property (@(posedge clk) disable iff (arst || srst)
        (frame_done && enable) |=> !frame_done);
    a_rise_count: assert property (@(posedge clk) disable iff (arst)
        frame_done |-> (dbg_rises == (BIT_W+1)'(DATA_WIDTH)));
`endif
endmodule
